// File: rtl/uart_verici_hakem_if.sv
// Bundle between the uart_verici_hakem arbiter, its byte sources and the transmitter.
// The arbiter side uses the master modport; the environment side uses slave.
interface uart_verici_hakem_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req_gecerli_i;
    logic [8*N_REQ-1:0] req_veri_i;
    logic [N_REQ-1:0]   req_son_i;
    logic [N_REQ-1:0]   req_consume_o;
    logic               tx_gecerli_o;
    logic [7:0]         tx_veri_o;
    logic               tx_consume_i;
    logic               mesgul_o;
    logic [2:0]         aktif_istekci_o;
    logic               zaman_asimi_o;

    modport master (
        input  req_gecerli_i, req_veri_i, req_son_i, tx_consume_i,
        output req_consume_o, tx_gecerli_o, tx_veri_o, mesgul_o, aktif_istekci_o, zaman_asimi_o
    );

    modport slave (
        output req_gecerli_i, req_veri_i, req_son_i, tx_consume_i,
        input  req_consume_o, tx_gecerli_o, tx_veri_o, mesgul_o, aktif_istekci_o, zaman_asimi_o
    );
endinterface

// File: rtl/uart_verici_hakem.sv
// Round-robin, message-locked arbiter feeding one uart_verici through a one-byte holding register.
// Optional idle-timeout release of a locked grant: define UART_HAKEM_ZAMAN_ASIMI_EN.
module uart_verici_hakem #(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    uart_verici_hakem_if.master bus
);
    typedef enum logic {BOSTA, KILITLI} durum_t;

    durum_t      durum_r;
    logic [2:0]  sec_r;
    logic [2:0]  son_kazanan_r;
    logic [2:0]  aday;
    logic        bulundu;
    logic [3:0]  toplam;
    logic        dolu_r;
    logic [7:0]  veri_r;
    logic        yukle;
    logic        gecerli_sec;
    logic        son_sec;
    logic [7:0]  veri_sec;
    logic [7:0]  gecerli_pad;
    logic [7:0]  son_pad;
    logic [63:0] veri_pad;

`ifdef UART_HAKEM_ZAMAN_ASIMI_EN
    localparam logic [15:0] ESIK = 16'(TIMEOUT_CYC - 1);
    logic [15:0] sayac_r;
    logic        zaman_asimi_r;
`endif

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65536) begin : g_param_hata
        $error("uart_verici_hakem: parameter out of range");
    end

    // Widen request vectors to 8 lanes so a 3-bit index selects without width games.
    assign gecerli_pad = 8'(bus.req_gecerli_i);
    assign son_pad     = 8'(bus.req_son_i);
    assign veri_pad    = 64'(bus.req_veri_i);

    assign gecerli_sec = gecerli_pad[sec_r];
    assign son_sec     = son_pad[sec_r];
    assign veri_sec    = veri_pad[{sec_r, 3'b000} +: 8];

    // First valid requester after the previous winner, wrapping modulo N_REQ.
    always_comb begin
        bulundu = 1'b0;
        aday    = 3'd0;
        toplam  = 4'd0;
        for (int k = 1; k <= N_REQ; k++) begin
            toplam = 4'(son_kazanan_r) + 4'(k);
            if (toplam >= 4'(N_REQ)) begin
                toplam = toplam - 4'(N_REQ);
            end
            if (!bulundu && gecerli_pad[toplam[2:0]]) begin
                bulundu = 1'b1;
                aday    = toplam[2:0];
            end
        end
    end

    assign yukle = (durum_r == KILITLI) && gecerli_sec && (!dolu_r || bus.tx_consume_i);

    assign bus.req_consume_o   = yukle ? (N_REQ'(1) << sec_r) : '0;
    assign bus.tx_gecerli_o    = dolu_r;
    assign bus.tx_veri_o       = veri_r;
    assign bus.mesgul_o        = (durum_r == KILITLI);
    assign bus.aktif_istekci_o = sec_r;
`ifdef UART_HAKEM_ZAMAN_ASIMI_EN
    assign bus.zaman_asimi_o   = zaman_asimi_r;
`else
    assign bus.zaman_asimi_o   = 1'b0;
`endif

    // A simultaneous drain and load simply reloads, so the transmitter never sees a bubble.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            durum_r       <= BOSTA;
            sec_r         <= 3'd0;
            son_kazanan_r <= 3'(N_REQ - 1);
            dolu_r        <= 1'b0;
            veri_r        <= 8'd0;
`ifdef UART_HAKEM_ZAMAN_ASIMI_EN
            sayac_r       <= 16'd0;
            zaman_asimi_r <= 1'b0;
`endif
        end else begin
`ifdef UART_HAKEM_ZAMAN_ASIMI_EN
            zaman_asimi_r <= 1'b0;
`endif
            if (yukle) begin
                dolu_r <= 1'b1;
                veri_r <= veri_sec;
            end else if (bus.tx_consume_i) begin
                dolu_r <= 1'b0;
            end

            case (durum_r)
                BOSTA: begin
                    if (bulundu) begin
                        sec_r   <= aday;
                        durum_r <= KILITLI;
`ifdef UART_HAKEM_ZAMAN_ASIMI_EN
                        sayac_r <= 16'd0;
`endif
                    end
                end
                KILITLI: begin
                    if (yukle) begin
`ifdef UART_HAKEM_ZAMAN_ASIMI_EN
                        sayac_r <= 16'd0;
`endif
                        if (son_sec) begin
                            durum_r       <= BOSTA;
                            son_kazanan_r <= sec_r;
                        end
                    end
`ifdef UART_HAKEM_ZAMAN_ASIMI_EN
                    // Only an absent source counts as idle; a source stalled by a full register does not.
                    else if (!gecerli_sec) begin
                        if (sayac_r == ESIK) begin
                            durum_r       <= BOSTA;
                            son_kazanan_r <= sec_r;
                            zaman_asimi_r <= 1'b1;
                        end else begin
                            sayac_r <= sayac_r + 16'd1;
                        end
                    end
`endif
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_verici_hakem.sv
// Self-checking bench for uart_verici_hakem: message-level round-robin model plus directed cycle tables.
// Build with UART_HAKEM_ZAMAN_ASIMI_EN to exercise the timeout release instead of the permanent lock.
module tb_uart_verici_hakem;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rstn;

    uart_verici_hakem_if #(.N_REQ(N)) bus ();

    uart_verici_hakem #(.N_REQ(N), .TIMEOUT_CYC(16)) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int         n_assert = 0;
    int         n_fail   = 0;
    logic [8:0] tab [N][16];
    int         adet [N];
    int         bas [N];
    int         cons_say [N];
    logic [3:0] pops;
    logic [7:0] bekl_tx [$];
    int         bekl_grant [$];
    logic [7:0] obs_tx [$];
    int         obs_grant [$];
    int         model_last;
    int         gecikme;
    int         bekle;
    bit         izle;
    int         zaman_say;

    logic       prev_gec, prev_txc, prev_mes;
    logic [7:0] prev_veri;
    logic [7:0] g8, e8;
    logic [2:0] a3;

    task automatic check_value(input string ad, input logic [31:0] gercek, input logic [31:0] beklenen);
        n_assert++;
        if (gercek !== beklenen) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", ad, gercek, beklenen, $time);
        end
    endtask

    task automatic fail_now(input string ad);
        n_assert++;
        n_fail++;
        $display("[TB] FAIL %s: bound expired at t=%0t", ad, $time);
    endtask

    task automatic add_byte(input int r, input logic [7:0] b, input bit s);
        tab[r][adet[r]] = {s, b};
        adet[r]++;
    endtask

    // Message-level expectation: whole messages in round-robin order from the last winner.
    task automatic plan_model();
        int  p [N];
        int  j;
        int  c;
        bit  tamam;
        for (int i = 0; i < N; i++) p[i] = bas[i];
        for (int iter = 0; iter < 64; iter++) begin
            j = -1;
            for (int k = 1; k <= N; k++) begin
                c = (model_last + k) % N;
                if (j < 0 && p[c] < adet[c]) j = c;
            end
            if (j < 0) break;
            bekl_grant.push_back(j);
            tamam = 1'b0;
            while (p[j] < adet[j] && !tamam) begin
                bekl_tx.push_back(tab[j][p[j]][7:0]);
                tamam = tab[j][p[j]][8];
                p[j]++;
            end
`ifndef UART_HAKEM_ZAMAN_ASIMI_EN
            if (!tamam) break;
`endif
            model_last = j;
        end
    endtask

    task automatic drive_inputs();
        logic [N-1:0]   g;
        logic [N-1:0]   s;
        logic [8*N-1:0] v;
        g = '0;
        s = '0;
        v = '0;
        for (int i = 0; i < N; i++) begin
            if (bas[i] < adet[i]) begin
                g[i]       = 1'b1;
                s[i]       = tab[i][bas[i]][8];
                v[8*i +: 8] = tab[i][bas[i]][7:0];
            end
        end
        bus.req_gecerli_i = g;
        bus.req_son_i     = s;
        bus.req_veri_i    = v;
        if (bus.tx_gecerli_o) begin
            if (bekle >= gecikme) begin
                bus.tx_consume_i = 1'b1;
                bekle = 0;
            end else begin
                bus.tx_consume_i = 1'b0;
                bekle++;
            end
        end else begin
            bus.tx_consume_i = 1'b0;
            bekle = 0;
        end
    endtask

    task automatic apply_stimulus();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (pops[i]) bas[i]++;
        pops = '0;
        drive_inputs();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        izle = 1'b0;
        for (int i = 0; i < N; i++) begin
            adet[i]     = 0;
            bas[i]      = 0;
            cons_say[i] = 0;
        end
        pops = '0;
        bekl_tx.delete();
        bekl_grant.delete();
        obs_tx.delete();
        obs_grant.delete();
        model_last = N - 1;
        bekle      = 0;
        zaman_say  = 0;
        bus.req_gecerli_i = '0;
        bus.req_son_i     = '0;
        bus.req_veri_i    = '0;
        bus.tx_consume_i  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        izle = 1'b1;
    endtask

    task automatic run_until_idle(input int budget, input string ad);
        bit bitti;
        bitti = 1'b0;
        for (int c = 0; c < budget && !bitti; c++) begin
            bitti = (bekl_tx.size() == 0) && !bus.tx_gecerli_o && !bus.mesgul_o;
            for (int i = 0; i < N; i++) if (bas[i] < adet[i]) bitti = 1'b0;
            if (!bitti) apply_stimulus();
        end
        if (!bitti) fail_now(ad);
    endtask

    task automatic check_tx_seq(input string ad, input logic [7:0] beklenen [$]);
        check_value({ad, "_len"}, 32'(obs_tx.size()), 32'(beklenen.size()));
        for (int i = 0; i < beklenen.size() && i < obs_tx.size(); i++)
            check_value($sformatf("%s[%0d]", ad, i), 32'(obs_tx[i]), 32'(beklenen[i]));
    endtask

    task automatic check_grant_seq(input string ad, input int beklenen [$]);
        check_value({ad, "_len"}, 32'(obs_grant.size()), 32'(beklenen.size()));
        for (int i = 0; i < beklenen.size() && i < obs_grant.size(); i++)
            check_value($sformatf("%s[%0d]", ad, i), 32'(obs_grant[i]), 32'(beklenen[i]));
    endtask

    // Per-cycle comparison against the model, sampled on the falling edge.
    initial begin
        prev_gec = 1'b0; prev_txc = 1'b0; prev_mes = 1'b0; prev_veri = 8'd0;
        forever begin
            @(negedge clk);
            if (!rstn || !izle) begin
                prev_gec = 1'b0; prev_txc = 1'b0; prev_mes = 1'b0;
            end else begin
                g8 = 8'(bus.req_gecerli_i);
                a3 = bus.aktif_istekci_o;
                e8 = 8'd0;
                if (bus.mesgul_o && g8[a3] && (!bus.tx_gecerli_o || bus.tx_consume_i)) e8 = 8'd1 << a3;
                check_value("consume", 32'(bus.req_consume_o), 32'(e8));
                if (bus.mesgul_o && !prev_mes) begin
                    obs_grant.push_back(int'(a3));
                    if (bekl_grant.size() == 0) fail_now("grant_unexpected");
                    else check_value("grant", 32'(a3), 32'(bekl_grant.pop_front()));
                end
                if (bus.tx_gecerli_o && bus.tx_consume_i) begin
                    obs_tx.push_back(bus.tx_veri_o);
                    if (bekl_tx.size() == 0) fail_now("tx_byte_unexpected");
                    else check_value("tx_byte", 32'(bus.tx_veri_o), 32'(bekl_tx.pop_front()));
                end
                if (prev_gec && !prev_txc) begin
                    check_value("hold_valid", 32'(bus.tx_gecerli_o), 32'd1);
                    check_value("hold_data", 32'(bus.tx_veri_o), 32'(prev_veri));
                end
`ifdef UART_HAKEM_ZAMAN_ASIMI_EN
                if (bus.zaman_asimi_o) zaman_say++;
`else
                check_value("zaman_asimi", 32'(bus.zaman_asimi_o), 32'd0);
`endif
                for (int i = 0; i < N; i++) begin
                    if (bus.req_consume_o[i]) begin
                        pops[i] = 1'b1;
                        cons_say[i]++;
                    end
                end
                prev_gec  = bus.tx_gecerli_o;
                prev_txc  = bus.tx_consume_i;
                prev_mes  = bus.mesgul_o;
                prev_veri = bus.tx_veri_o;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int exp_mes  [9];
        int exp_cons [9];
        int exp_gec  [9];
        int exp_veri [9];
        exp_mes  = '{0, 1, 1, 1, 1, 1, 0, 0, 0};
        exp_cons = '{0, 1, 0, 1, 0, 1, 0, 0, 0};
        exp_gec  = '{0, 0, 1, 1, 1, 1, 1, 1, 0};
        exp_veri = '{8'h00, 8'h00, 8'h41, 8'h41, 8'h42, 8'h42, 8'h43, 8'h43, 8'h43};

        rstn = 1'b0;
        izle = 1'b0;
        pops = '0;
        bus.req_gecerli_i = '0;
        bus.req_son_i     = '0;
        bus.req_veri_i    = '0;
        bus.tx_consume_i  = 1'b0;

        #2;
        check_value("rst_tx_gecerli", 32'(bus.tx_gecerli_o), 32'd0);
        check_value("rst_tx_veri", 32'(bus.tx_veri_o), 32'd0);
        check_value("rst_mesgul", 32'(bus.mesgul_o), 32'd0);
        check_value("rst_aktif", 32'(bus.aktif_istekci_o), 32'd0);
        check_value("rst_consume", 32'(bus.req_consume_o), 32'd0);
        check_value("rst_zaman_asimi", 32'(bus.zaman_asimi_o), 32'd0);

        $display("[TB] single source");
        do_reset();
        add_byte(0, 8'h41, 1'b0);
        add_byte(0, 8'h42, 1'b0);
        add_byte(0, 8'h43, 1'b1);
        plan_model();
        gecikme = 1;
        for (int c = 0; c < 9; c++) begin
            apply_stimulus();
            #1;
            check_value($sformatf("single_mesgul[%0d]", c), 32'(bus.mesgul_o), 32'(exp_mes[c]));
            check_value($sformatf("single_consume[%0d]", c), 32'(bus.req_consume_o), 32'(exp_cons[c]));
            check_value($sformatf("single_gecerli[%0d]", c), 32'(bus.tx_gecerli_o), 32'(exp_gec[c]));
            check_value($sformatf("single_veri[%0d]", c), 32'(bus.tx_veri_o), 32'(exp_veri[c]));
        end
        run_until_idle(50, "single_drain");
        check_value("single_pop_count", 32'(cons_say[0]), 32'd3);
        check_tx_seq("single_tx", '{8'h41, 8'h42, 8'h43});

        $display("[TB] contention");
        do_reset();
        add_byte(0, 8'hA0, 1'b0);
        add_byte(0, 8'hA1, 1'b1);
        add_byte(2, 8'hC0, 1'b0);
        add_byte(2, 8'hC1, 1'b1);
        plan_model();
        gecikme = 1;
        run_until_idle(100, "contention_drain");
        check_grant_seq("contention_grant", '{0, 2});
        check_tx_seq("contention_tx", '{8'hA0, 8'hA1, 8'hC0, 8'hC1});

        $display("[TB] fairness");
        do_reset();
        for (int i = 0; i < N; i++) begin
            add_byte(i, 8'(8'h10 + i), 1'b1);
            add_byte(i, 8'(8'h20 + i), 1'b1);
        end
        plan_model();
        gecikme = 1;
        run_until_idle(300, "fairness_drain");
        check_grant_seq("fairness_grant", '{0, 1, 2, 3, 0, 1, 2, 3});
        check_tx_seq("fairness_tx", '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21, 8'h22, 8'h23});

        $display("[TB] back-to-back");
        do_reset();
        for (int i = 1; i <= 5; i++) add_byte(1, 8'(8'h60 + i), (i == 5));
        plan_model();
        gecikme = 0;
        for (int c = 0; c < 8; c++) begin
            apply_stimulus();
            #1;
            check_value($sformatf("b2b_gecerli[%0d]", c), 32'(bus.tx_gecerli_o), 32'((c >= 2 && c <= 6) ? 1 : 0));
            check_value($sformatf("b2b_consume[%0d]", c), 32'(bus.req_consume_o), 32'((c >= 1 && c <= 5) ? 2 : 0));
            if (c >= 2 && c <= 6)
                check_value($sformatf("b2b_veri[%0d]", c), 32'(bus.tx_veri_o), 32'(8'h60 + c - 1));
        end
        run_until_idle(50, "b2b_drain");
        check_tx_seq("b2b_tx", '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65});

        $display("[TB] asynchronous reset mid-message");
        do_reset();
        add_byte(3, 8'h71, 1'b0);
        add_byte(3, 8'h72, 1'b0);
        add_byte(3, 8'h73, 1'b1);
        plan_model();
        gecikme = 3;
        repeat (3) apply_stimulus();
        #1;
        check_value("pre_reset_mesgul", 32'(bus.mesgul_o), 32'd1);
        check_value("pre_reset_gecerli", 32'(bus.tx_gecerli_o), 32'd1);
        check_value("pre_reset_aktif", 32'(bus.aktif_istekci_o), 32'd3);
        #1;
        izle = 1'b0;
        rstn = 1'b0;
        #1;
        check_value("async_reset_gecerli", 32'(bus.tx_gecerli_o), 32'd0);
        check_value("async_reset_mesgul", 32'(bus.mesgul_o), 32'd0);
        check_value("async_reset_consume", 32'(bus.req_consume_o), 32'd0);
        do_reset();
        add_byte(0, 8'h81, 1'b1);
        add_byte(3, 8'h91, 1'b1);
        plan_model();
        gecikme = 1;
        run_until_idle(100, "post_reset_drain");
        check_grant_seq("post_reset_grant", '{0, 3});
        check_tx_seq("post_reset_tx", '{8'h81, 8'h91});

        $display("[TB] idle lock");
        do_reset();
        add_byte(1, 8'h55, 1'b0);
        add_byte(2, 8'h66, 1'b1);
        plan_model();
        gecikme = 1;
`ifdef UART_HAKEM_ZAMAN_ASIMI_EN
        run_until_idle(200, "timeout_drain");
        check_value("timeout_pulses", 32'(zaman_say), 32'd1);
        check_grant_seq("timeout_grant", '{1, 2});
        check_tx_seq("timeout_tx", '{8'h55, 8'h66});
`else
        for (int c = 0; c < 200; c++) begin
            apply_stimulus();
            #1;
            if (c >= 1) begin
                check_value($sformatf("lock_mesgul[%0d]", c), 32'(bus.mesgul_o), 32'd1);
                check_value($sformatf("lock_aktif[%0d]", c), 32'(bus.aktif_istekci_o), 32'd1);
            end
        end
        check_value("lock_req2_untouched", 32'(bas[2]), 32'd0);
        check_grant_seq("lock_grant", '{1});
        check_tx_seq("lock_tx", '{8'h55});
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
